// File: rtl/prt_scaler_krnl_mac_pipe_if.sv
// rtl/prt_scaler_krnl_mac_pipe_if.sv - sample/coefficient bus for the scaler kernel MAC pipe
//
// Purpose: groups the per-cycle control, sample input and filtered output signals
//          of prt_scaler_krnl_mac_pipe so the line/tap buffer side and the
//          formatter side connect through a single port.
// Signals:
//   EN_IN         pipeline advance (0 freezes every stage)
//   VLD_IN        C_IN/P_IN carry a valid sample
//   C_IN          P_TAPS signed coefficients, tap t at [t*P_CW +: P_CW]
//   P_IN          P_CH*P_TAPS unsigned pixels, channel c tap t at [(c*P_TAPS+t)*P_BPC +: P_BPC]
//   CLR_IN        synchronous clear of STA_CLIP_OUT
//   VLD_OUT       P_OUT/CLIP_OUT valid
//   P_OUT         filtered pixel, channel c at [c*P_BPC +: P_BPC]
//   CLIP_OUT      any channel of the output sample clipped
//   STA_CLIP_OUT  sticky clip status
// Modports: master drives samples/controls, slave is the kernel.
interface prt_scaler_krnl_mac_pipe_if #(
    parameter int P_BPC  = 8,
    parameter int P_CH   = 3,
    parameter int P_TAPS = 4,
    parameter int P_CW   = 10
);
    logic                            EN_IN;
    logic                            VLD_IN;
    logic [P_TAPS*P_CW-1:0]          C_IN;
    logic [P_CH*P_TAPS*P_BPC-1:0]    P_IN;
    logic                            CLR_IN;
    logic                            VLD_OUT;
    logic [P_CH*P_BPC-1:0]           P_OUT;
    logic                            CLIP_OUT;
    logic                            STA_CLIP_OUT;

    modport master (
        output EN_IN, VLD_IN, C_IN, P_IN, CLR_IN,
        input  VLD_OUT, P_OUT, CLIP_OUT, STA_CLIP_OUT
    );

    modport slave (
        input  EN_IN, VLD_IN, C_IN, P_IN, CLR_IN,
        output VLD_OUT, P_OUT, CLIP_OUT, STA_CLIP_OUT
    );
endinterface

// File: rtl/prt_scaler_krnl_mac_pipe.sv
// rtl/prt_scaler_krnl_mac_pipe.sv - multi-channel N-tap signed-coefficient MAC kernel for the video scaler
//
// Purpose: per channel, multiplies P_TAPS unsigned pixels by a shared set of
//          signed coefficients, sums them at full precision through a pipelined
//          binary adder tree, then rounds, shifts by P_CF and clips to P_BPC bits.
//          Latency is 2+log2(P_TAPS) enabled cycles; a valid bit travels with the data.
// Ports:
//   CLK_IN   clock
//   RST_IN   asynchronous reset, active-low
//   bus      slave side of prt_scaler_krnl_mac_pipe_if (controls, samples, results, clip status)
module prt_scaler_krnl_mac_pipe #(
    parameter int P_BPC   = 8,
    parameter int P_CH    = 3,
    parameter int P_TAPS  = 4,
    parameter int P_CW    = 10,
    parameter int P_CF    = 8,
    parameter int P_ROUND = 1
) (
    input  logic                          CLK_IN,
    input  logic                          RST_IN,
    prt_scaler_krnl_mac_pipe_if.slave     bus
);
    localparam int LG = $clog2(P_TAPS);
    localparam int PW = P_BPC + P_CW + 1;       // product width
    localparam int SW = PW + LG;                // full-precision sum width
    localparam int RW = SW + 1;                 // room for the rounding add
    localparam int NN = 2 * P_TAPS - 1;         // adder tree nodes per channel

    localparam logic signed [RW-1:0] RND  = (P_ROUND != 0) ? RW'(2 ** (P_CF - 1)) : RW'(0);
    localparam logic signed [RW-1:0] PMAX = RW'((2 ** P_BPC) - 1);

    // Adder tree stored as a heap: node i has children 2i+1 and 2i+2, the
    // leaves (indices P_TAPS-1 .. 2*P_TAPS-2) hold the registered products and
    // node 0 is the root. Every node is a register, so each tree level is one
    // pipeline stage and the root lags the leaves by exactly log2(P_TAPS) edges.
    logic signed [SW-1:0]   node_q [P_CH][NN];
    logic        [LG:0]     vld_q;              // [0] = product stage, [LG] = root stage

    logic signed [PW-1:0]   prod   [P_CH][P_TAPS];
    logic [P_CH*P_BPC-1:0]  pix_res;
    logic [P_CH-1:0]        clip_ch;
    logic                   any_clip;

    always_comb begin
        logic signed [PW-1:0] pix_s;
        logic signed [PW-1:0] coef_s;
        pix_s  = '0;
        coef_s = '0;
        for (int c = 0; c < P_CH; c++) begin
            for (int t = 0; t < P_TAPS; t++) begin
                // Pixel is zero-extended so it stays positive in the signed multiply.
                pix_s  = PW'($signed({1'b0, bus.P_IN[(c*P_TAPS+t)*P_BPC +: P_BPC]}));
                coef_s = PW'($signed(bus.C_IN[t*P_CW +: P_CW]));
                prod[c][t] = pix_s * coef_s;
            end
        end
    end

    always_comb begin
        logic signed [RW-1:0] rnd_v;
        logic signed [RW-1:0] shr_v;
        rnd_v   = '0;
        shr_v   = '0;
        pix_res = '0;
        clip_ch = '0;
        for (int c = 0; c < P_CH; c++) begin
            rnd_v = RW'(node_q[c][0]) + RND;
            shr_v = rnd_v >>> P_CF;             // arithmetic: truncation goes toward -inf
            if (shr_v[RW-1]) begin
                pix_res[c*P_BPC +: P_BPC] = '0;
                clip_ch[c]                = 1'b1;
            end else if (shr_v > PMAX) begin
                pix_res[c*P_BPC +: P_BPC] = '1;
                clip_ch[c]                = 1'b1;
            end else begin
                pix_res[c*P_BPC +: P_BPC] = shr_v[P_BPC-1:0];
                clip_ch[c]                = 1'b0;
            end
        end
        any_clip = |clip_ch;
    end

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            for (int c = 0; c < P_CH; c++) begin
                for (int i = 0; i < NN; i++) begin
                    node_q[c][i] <= '0;
                end
            end
            vld_q            <= '0;
            bus.VLD_OUT      <= 1'b0;
            bus.P_OUT        <= '0;
            bus.CLIP_OUT     <= 1'b0;
            bus.STA_CLIP_OUT <= 1'b0;
        end else begin
            if (bus.EN_IN) begin
                vld_q <= {vld_q[LG-1:0], bus.VLD_IN};
                for (int c = 0; c < P_CH; c++) begin
                    for (int t = 0; t < P_TAPS; t++) begin
                        node_q[c][P_TAPS-1+t] <= {{LG{prod[c][t][PW-1]}}, prod[c][t]};
                    end
                    for (int i = 0; i < P_TAPS - 1; i++) begin
                        node_q[c][i] <= node_q[c][2*i+1] + node_q[c][2*i+2];
                    end
                end
                // Invalid samples still move through so the data path never
                // needs a bubble-squeeze; their clip status is masked off.
                bus.VLD_OUT  <= vld_q[LG];
                bus.P_OUT    <= pix_res;
                bus.CLIP_OUT <= vld_q[LG] & any_clip;
            end
            // Set has priority so a clip landing on the clear edge is not lost.
            if (bus.EN_IN && vld_q[LG] && any_clip) begin
                bus.STA_CLIP_OUT <= 1'b1;
            end else if (bus.CLR_IN) begin
                bus.STA_CLIP_OUT <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_prt_scaler_krnl_mac_pipe.sv
// tb/tb_prt_scaler_krnl_mac_pipe.sv - self-checking bench for prt_scaler_krnl_mac_pipe
module tb_prt_scaler_krnl_mac_pipe;
    localparam int P_BPC   = 8;
    localparam int P_CH    = 3;
    localparam int P_TAPS  = 4;
    localparam int P_CW    = 10;
    localparam int P_CF    = 8;
    localparam int P_ROUND = 1;
    localparam int CWID    = P_TAPS * P_CW;
    localparam int PWID    = P_CH * P_TAPS * P_BPC;
    localparam int OWID    = P_CH * P_BPC;

    typedef struct packed {
        logic [OWID-1:0] pix;
        logic            clip;
    } exp_t;

    logic CLK_IN = 1'b0;
    logic RST_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    prt_scaler_krnl_mac_pipe_if #(
        .P_BPC(P_BPC), .P_CH(P_CH), .P_TAPS(P_TAPS), .P_CW(P_CW)
    ) bus ();

    prt_scaler_krnl_mac_pipe #(
        .P_BPC(P_BPC), .P_CH(P_CH), .P_TAPS(P_TAPS), .P_CW(P_CW),
        .P_CF(P_CF), .P_ROUND(P_ROUND)
    ) u_dut (
        .CLK_IN (CLK_IN),
        .RST_IN (RST_IN),
        .bus    (bus)
    );

    int   total   = 0;
    int   bad     = 0;
    int   vld_cnt = 0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [CWID-1:0] c, input logic [PWID-1:0] p);
        exp_t   e;
        longint s;
        e = '0;
        for (int ch = 0; ch < P_CH; ch++) begin
            s = 0;
            for (int t = 0; t < P_TAPS; t++) begin
                s += longint'(p[(ch*P_TAPS+t)*P_BPC +: P_BPC]) * longint'($signed(c[t*P_CW +: P_CW]));
            end
            if (P_ROUND != 0) s += longint'(1) << (P_CF - 1);
            s = s >>> P_CF;
            if (s < 0) begin
                e.pix[ch*P_BPC +: P_BPC] = '0;
                e.clip = 1'b1;
            end else if (s > (2 ** P_BPC) - 1) begin
                e.pix[ch*P_BPC +: P_BPC] = '1;
                e.clip = 1'b1;
            end else begin
                e.pix[ch*P_BPC +: P_BPC] = P_BPC'(s);
            end
        end
        return e;
    endfunction

    function automatic logic [CWID-1:0] mk_c(input int c0, input int c1, input int c2, input int c3);
        logic [CWID-1:0] v;
        v = {P_CW'(c3), P_CW'(c2), P_CW'(c1), P_CW'(c0)};
        return v;
    endfunction

    function automatic logic [PWID-1:0] mk_p(input int p0, input int p1, input int p2, input int p3);
        logic [PWID-1:0] v;
        for (int ch = 0; ch < P_CH; ch++) begin
            v[(ch*P_TAPS+0)*P_BPC +: P_BPC] = P_BPC'(p0);
            v[(ch*P_TAPS+1)*P_BPC +: P_BPC] = P_BPC'(p1);
            v[(ch*P_TAPS+2)*P_BPC +: P_BPC] = P_BPC'(p2);
            v[(ch*P_TAPS+3)*P_BPC +: P_BPC] = P_BPC'(p3);
        end
        return v;
    endfunction

    function automatic logic [PWID-1:0] mk_ramp(input int k);
        logic [PWID-1:0] v;
        v = PWID'({$urandom, $urandom, $urandom});
        for (int ch = 0; ch < P_CH; ch++) begin
            v[(ch*P_TAPS)*P_BPC +: P_BPC] = P_BPC'(k + 10 * ch);
        end
        return v;
    endfunction

    // One clock; checks any output the DUT produced on an enabled edge against the scoreboard.
    task automatic tick();
        logic en_s;
        exp_t e;
        en_s = bus.EN_IN;
        @(posedge CLK_IN);
        #1;
        if (en_s && RST_IN && bus.VLD_OUT) begin
            vld_cnt++;
            chk("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("p_out", 64'(bus.P_OUT), 64'(e.pix));
                chk("clip_out", 64'(bus.CLIP_OUT), 64'(e.clip));
            end
        end
    endtask

    task automatic send(input logic v, input logic [CWID-1:0] c, input logic [PWID-1:0] p);
        bus.VLD_IN = v;
        bus.C_IN   = c;
        bus.P_IN   = p;
        if (v && bus.EN_IN) exp_q.push_back(model(c, p));
        tick();
        bus.VLD_IN = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OWID-1:0] held_p;
        logic            held_v;
        int              v0;

        bus.EN_IN  = 1'b1;
        bus.VLD_IN = 1'b0;
        bus.CLR_IN = 1'b0;
        bus.C_IN   = '0;
        bus.P_IN   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_vld", 64'(bus.VLD_OUT), 64'(0));
        chk("rst_pout", 64'(bus.P_OUT), 64'(0));
        chk("rst_clip", 64'(bus.CLIP_OUT), 64'(0));
        chk("rst_sta", 64'(bus.STA_CLIP_OUT), 64'(0));
        RST_IN = 1'b1;

        // Identity with exact latency
        send(1'b1, mk_c(256, 0, 0, 0), mk_p(200, 7, 9, 11));
        tick();
        chk("lat_e2_vld", 64'(bus.VLD_OUT), 64'(0));
        tick();
        chk("lat_e3_vld", 64'(bus.VLD_OUT), 64'(0));
        tick();
        chk("lat_e4_vld", 64'(bus.VLD_OUT), 64'(1));
        chk("ident_pout", 64'(bus.P_OUT), 64'({P_CH{8'd200}}));
        tick();
        chk("lat_e5_vld", 64'(bus.VLD_OUT), 64'(0));

        // Rounding, then both negative-lobe samples back to back
        send(1'b1, mk_c(64, 64, 64, 64), mk_p(10, 20, 30, 42));
        send(1'b1, mk_c(-32, 160, 160, -32), mk_p(255, 0, 0, 255));
        send(1'b1, mk_c(-32, 160, 160, -32), mk_p(0, 100, 100, 0));
        drain();
        tick();
        tick();
        chk("sta_sticky", 64'(bus.STA_CLIP_OUT), 64'(1));
        bus.CLR_IN = 1'b1;
        tick();
        bus.CLR_IN = 1'b0;
        chk("sta_cleared", 64'(bus.STA_CLIP_OUT), 64'(0));

        // Overflow clip landing on an edge with clear asserted
        bus.CLR_IN = 1'b1;
        send(1'b1, mk_c(256, 256, 256, 256), mk_p(255, 255, 255, 255));
        tick();
        tick();
        tick();
        chk("ovf_vld", 64'(bus.VLD_OUT), 64'(1));
        chk("sta_set_wins", 64'(bus.STA_CLIP_OUT), 64'(1));
        tick();
        chk("sta_clr_after", 64'(bus.STA_CLIP_OUT), 64'(0));
        bus.CLR_IN = 1'b0;
        send(1'b1, mk_c(256, 256, 256, 256), mk_p(255, 255, 255, 255));
        drain();
        chk("sta_set_again", 64'(bus.STA_CLIP_OUT), 64'(1));
        bus.CLR_IN = 1'b1;
        tick();
        bus.CLR_IN = 1'b0;

        // Ramp with a 3-cycle stall mid-stream
        v0 = vld_cnt;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                bus.EN_IN  = 1'b0;
                bus.VLD_IN = 1'b1;
                bus.C_IN   = mk_c(256, 256, 256, 256);
                bus.P_IN   = '1;
                held_p = bus.P_OUT;
                held_v = bus.VLD_OUT;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_pout", 64'(bus.P_OUT), 64'(held_p));
                    chk("stall_vld", 64'(bus.VLD_OUT), 64'(held_v));
                end
                bus.EN_IN = 1'b1;
            end
            send(1'b1, mk_c(256, 0, 0, 0), mk_ramp(k));
        end
        drain();
        chk("ramp_count", 64'(vld_cnt - v0), 64'(8));
        chk("ramp_no_clip_sta", 64'(bus.STA_CLIP_OUT), 64'(0));

        // Reset with samples in flight
        send(1'b1, mk_c(256, 256, 256, 256), mk_p(255, 255, 255, 255));
        send(1'b1, mk_c(256, 0, 0, 0), mk_p(50, 0, 0, 0));
        send(1'b1, mk_c(256, 0, 0, 0), mk_p(60, 0, 0, 0));
        send(1'b1, mk_c(256, 0, 0, 0), mk_p(70, 0, 0, 0));
        chk("pre_rst_sta", 64'(bus.STA_CLIP_OUT), 64'(1));
        #2;
        RST_IN = 1'b0;
        #1;
        chk("async_rst_vld", 64'(bus.VLD_OUT), 64'(0));
        chk("async_rst_pout", 64'(bus.P_OUT), 64'(0));
        chk("async_rst_sta", 64'(bus.STA_CLIP_OUT), 64'(0));
        chk("async_rst_clip", 64'(bus.CLIP_OUT), 64'(0));
        exp_q.delete();
        #2;
        RST_IN = 1'b1;
        v0 = vld_cnt;
        for (int i = 0; i < 8; i++) tick();
        chk("no_stale_vld", 64'(vld_cnt - v0), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
